// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and display/status outputs of stopwatch_ctrl.
// The master drives the buttons and tick; the slave is the stopwatch itself.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic       second_tick;
  logic       timer_enable;
  logic [1:0] state;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;
  logic       lap_active;
  logic       rollover;

  modport master (
    output start_stop, clear, lap, second_tick,
    input  timer_enable, state, disp_min, disp_sec, lap_active, rollover
  );
  modport slave (
    input  start_stop, clear, lap, second_tick,
    output timer_enable, state, disp_min, disp_sec, lap_active, rollover
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear FSM with a min:sec count.
// Define STOPWATCH_LAP_EN to build the lap-freeze display snapshot.
module stopwatch_ctrl #(
  parameter int MAX_MINUTES = 59
) (
  input logic            clk,
  input logic            nrst,
  stopwatch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10} state_t;

  localparam logic [5:0] LP_MAX_MIN = 6'(MAX_MINUTES);

  state_t     r_state, w_state_nxt;
  logic       r_ss_q, r_clr_q, r_armed;
  logic       w_ss_edge, w_clr_edge, w_tick_run, w_roll_nxt;
  logic [5:0] r_min, r_sec, w_min_nxt, w_sec_nxt;
  logic       r_rollover;

  // Edges are masked for the first cycle after reset so a button held
  // through reset release is absorbed into the history, not seen as a press.
  assign w_ss_edge  = r_armed & bus.start_stop & ~r_ss_q;
  assign w_clr_edge = r_armed & bus.clear & ~r_clr_q;
  assign w_tick_run = bus.second_tick & (r_state == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_edge) begin
      w_state_nxt = S_IDLE;
    end else if (w_ss_edge) begin
      case (r_state)
        S_RUN:   w_state_nxt = S_PAUSE;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_comb begin
    w_min_nxt  = r_min;
    w_sec_nxt  = r_sec;
    w_roll_nxt = 1'b0;
    if (w_clr_edge) begin
      w_min_nxt = '0;
      w_sec_nxt = '0;
    end else if (w_tick_run) begin
      if (r_sec == 6'd59) begin
        w_sec_nxt = '0;
        if (r_min == LP_MAX_MIN) begin
          w_min_nxt  = '0;
          w_roll_nxt = 1'b1;
        end else begin
          w_min_nxt = r_min + 6'd1;
        end
      end else begin
        w_sec_nxt = r_sec + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_ss_q     <= 1'b0;
      r_clr_q    <= 1'b0;
      r_armed    <= 1'b0;
      r_min      <= '0;
      r_sec      <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ss_q     <= bus.start_stop;
      r_clr_q    <= bus.clear;
      r_armed    <= 1'b1;
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_rollover <= w_roll_nxt;
    end
  end

  assign bus.timer_enable = (r_state == S_RUN);
  assign bus.state        = r_state;
  assign bus.rollover     = r_rollover;

`ifdef STOPWATCH_LAP_EN
  logic       r_lap_q, r_lap_active;
  logic [5:0] r_snap_min, r_snap_sec;
  logic       w_lap_edge;

  assign w_lap_edge = r_armed & bus.lap & ~r_lap_q;

  // Snapshot takes the pre-tick count; the live count keeps running.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_lap_q      <= 1'b0;
      r_lap_active <= 1'b0;
      r_snap_min   <= '0;
      r_snap_sec   <= '0;
    end else begin
      r_lap_q <= bus.lap;
      if (w_clr_edge) begin
        r_lap_active <= 1'b0;
      end else if (w_lap_edge && r_state == S_RUN) begin
        r_lap_active <= ~r_lap_active;
        if (!r_lap_active) begin
          r_snap_min <= r_min;
          r_snap_sec <= r_sec;
        end
      end
    end
  end

  assign bus.lap_active = r_lap_active;
  assign bus.disp_min   = r_lap_active ? r_snap_min : r_min;
  assign bus.disp_sec   = r_lap_active ? r_snap_sec : r_sec;
`else
  logic w_unused_lap;
  assign w_unused_lap   = bus.lap;
  assign bus.lap_active = 1'b0;
  assign bus.disp_min   = r_min;
  assign bus.disp_sec   = r_sec;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner
// sequences and a randomized run against a total-seconds reference model.
module tb_stopwatch_ctrl;
  localparam int MM   = 1;
  localparam int WRAP = (MM + 1) * 60;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();
  stopwatch_ctrl #(.MAX_MINUTES(MM)) dut (.clk(clk), .nrst(nrst), .bus(sw_if.slave));

  int n_chk = 0;
  int n_err = 0;

  // reference model: state in output encoding, count as total seconds
  int m_state, m_cnt, m_snap;
  bit m_la, m_roll, m_pss, m_pclr, m_plap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model(input bit n, input bit s, input bit c, input bit l, input bit t);
    bit es, ec, el;
    int old;
    if (!n) begin
      m_state = 0; m_cnt = 0; m_snap = 0; m_la = 0; m_roll = 0;
      m_pss = 1; m_pclr = 1; m_plap = 1;
    end else begin
      es = s && !m_pss; ec = c && !m_pclr; el = l && !m_plap;
      m_pss = s; m_pclr = c; m_plap = l;
      old = m_cnt;
      m_roll = 0;
      if (ec) begin
        m_state = 0; m_cnt = 0; m_la = 0;
      end else begin
        if (m_state == 1 && t) begin
          m_cnt  = (m_cnt + 1) % WRAP;
          m_roll = (m_cnt == 0);
        end
`ifdef STOPWATCH_LAP_EN
        if (el && m_state == 1) begin
          if (m_la) m_la = 0;
          else begin m_la = 1; m_snap = old; end
        end
`else
        if (el) m_snap = m_snap;
`endif
        if (es) m_state = (m_state == 1) ? 2 : 1;
      end
    end
  endtask

  function automatic logic [15:0] model_pack();
    int d;
    d = m_la ? m_snap : m_cnt;
    return {2'(m_state), (m_state == 1), 6'(d / 60), 6'(d % 60), m_la, m_roll};
  endfunction

  function automatic logic [15:0] dut_pack();
    return {sw_if.state, sw_if.timer_enable, sw_if.disp_min, sw_if.disp_sec,
            sw_if.lap_active, sw_if.rollover};
  endfunction

  task automatic step(input bit n, input bit s, input bit c, input bit l, input bit t);
    nrst = n;
    sw_if.start_stop = s; sw_if.clear = c; sw_if.lap = l; sw_if.second_tick = t;
    @(posedge clk);
    model(n, s, c, l, t);
    #1;
    chk("model", 32'(dut_pack()), 32'(model_pack()));
  endtask

  task automatic expect_out(input string name, input int st, input int mi, input int se,
                            input bit ro, input bit la);
    chk({name, ".state"}, 32'(sw_if.state), 32'(st));
    chk({name, ".timer_enable"}, 32'(sw_if.timer_enable), 32'(st == 1));
    chk({name, ".disp"}, {sw_if.disp_min, sw_if.disp_sec}, 32'(mi * 64 + se));
    chk({name, ".rollover"}, 32'(sw_if.rollover), 32'(ro));
    chk({name, ".lap_active"}, 32'(sw_if.lap_active), 32'(la));
  endtask

  typedef struct {
    bit n, s, c, l, t;
    int st, mi, se;
  } vec_t;
  vec_t tbl[17];

  initial begin
    // {nrst, start_stop, clear, lap, tick} -> {state, min, sec}
    tbl[0]  = '{0,0,0,0,0, 0,0,0};
    tbl[1]  = '{1,0,0,0,0, 0,0,0};
    tbl[2]  = '{1,1,0,0,0, 1,0,0};
    tbl[3]  = '{1,0,0,0,1, 1,0,1};
    tbl[4]  = '{1,0,0,0,1, 1,0,2};
    tbl[5]  = '{1,0,0,0,1, 1,0,3};
    tbl[6]  = '{1,1,0,0,1, 2,0,4};
    tbl[7]  = '{1,0,0,0,1, 2,0,4};
    tbl[8]  = '{1,1,0,0,0, 1,0,4};
    tbl[9]  = '{1,0,1,0,1, 0,0,0};
    tbl[10] = '{1,1,1,0,0, 1,0,0};
    tbl[11] = '{1,0,0,0,1, 1,0,1};
    tbl[12] = '{0,1,1,0,1, 0,0,0};
    tbl[13] = '{1,1,0,0,0, 0,0,0};
    tbl[14] = '{1,1,0,0,0, 0,0,0};
    tbl[15] = '{1,0,0,0,0, 0,0,0};
    tbl[16] = '{1,1,0,0,0, 1,0,0};

    nrst = 1'b0;
    sw_if.start_stop = 0; sw_if.clear = 0; sw_if.lap = 0; sw_if.second_tick = 0;

    foreach (tbl[i]) begin
      step(tbl[i].n, tbl[i].s, tbl[i].c, tbl[i].l, tbl[i].t);
      expect_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].mi, tbl[i].se, 0, 0);
    end

    // wrap at MAX_MINUTES:59 with a single-cycle rollover pulse
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 119; i++) step(1, 0, 0, 0, 1);
    expect_out("pre_wrap", 1, 1, 59, 0, 0);
    step(1, 0, 0, 0, 1);
    expect_out("wrap", 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    expect_out("wrap_after", 1, 0, 0, 0, 0);

    // ticks while paused are discarded
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    expect_out("paused", 2, 0, 5, 0, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    expect_out("resume", 1, 0, 6, 0, 0);

    // clear beats start_stop and swallows the tick
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    expect_out("at10", 1, 0, 10, 0, 0);
    step(1, 1, 1, 0, 1);
    expect_out("clr_prio", 0, 0, 0, 0, 0);

    // a held button yields one edge
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0);
      expect_out($sformatf("hold%0d", i), 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1);
    expect_out("hold_cnt", 1, 0, 3, 0, 0);
    step(0, 1, 1, 1, 1);
    expect_out("mid_reset", 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_out("held_thru_reset", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_out("repress", 1, 0, 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    expect_out("lap_on", 1, 0, 7, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    expect_out("lap_frozen", 1, 0, 7, 0, 1);
    step(1, 0, 0, 1, 0);
    expect_out("lap_off", 1, 0, 12, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    expect_out("lap_paused", 2, 0, 12, 0, 0);
    step(1, 0, 0, 0, 0);
`else
    step(1, 0, 0, 1, 1);
    expect_out("lap_ignored", 1, 0, 1, 0, 0);
`endif

    // random run against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 149) != 0,
           ($urandom_range(0, 3) == 0) ? ~sw_if.start_stop : sw_if.start_stop,
           ($urandom_range(0, 15) == 0) ? ~sw_if.clear : sw_if.clear,
           ($urandom_range(0, 5) == 0) ? ~sw_if.lap : sw_if.lap,
           $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter MAX_MINUTES, default 59: highest minute value before wrap to 00:00.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 nrst  input  1  reset, synchronous, active-low.
REQ-004 start_stop  input  1  level button; rising edge toggles run/pause.
REQ-005 clear  input  1  level button; rising edge zeroes the count.
REQ-006 lap  input  1  level button; rising edge toggles the lap freeze (LAP_EN builds only).
REQ-007 second_tick  input  1  one-cycle pulse from the seconds timer.
REQ-008 timer_enable  output  1  enable to the seconds timer; high only in RUNNING.
REQ-009 state  output  2  00 IDLE, 01 RUNNING, 10 PAUSED; 11 never driven.
REQ-010 disp_min  output  6  displayed minutes, 0..MAX_MINUTES.
REQ-011 disp_sec  output  6  displayed seconds, 0..59.
REQ-012 lap_active  output  1  display frozen at a lap snapshot.
REQ-013 rollover  output  1  one-cycle pulse when the count wraps MAX_MINUTES:59 -> 00:00.

Function
REQ-014 Edge detection: each button registered once per cycle; edge = current high and previous-sample low; an edge acts on the same clock edge it is detected; a held button produces exactly one edge.
REQ-015 IDLE + start_stop edge -> RUNNING; RUNNING + start_stop edge -> PAUSED; PAUSED + start_stop edge -> RUNNING.
REQ-016 clear edge in any state -> IDLE with count 00:00; clear has priority over start_stop and lap edges in the same cycle.
REQ-017 timer_enable is a decode of the state register (no extra cycle of latency).
REQ-018 Count (min, sec) increments only when second_tick is high and the state is RUNNING; a tick in IDLE or PAUSED is discarded, not deferred.
REQ-019 sec 59 + tick -> sec 0, min +1; min MAX_MINUTES, sec 59 + tick -> 00:00 with rollover high for that one cycle only.
REQ-020 Tick coincident with a start_stop edge while RUNNING: the tick is counted and the state becomes PAUSED.
REQ-021 Tick coincident with a clear edge: the count becomes 00:00 and the tick is lost.
REQ-022 Without a lap freeze, disp_min/disp_sec equal the live count registers.

Reset
REQ-023 When nrst is low at a clk edge: state IDLE, count 00:00, lap snapshot 00:00, lap_active 0, rollover 0, button history registers cleared to 0.
REQ-024 Reset mid-count takes effect on the next clk edge, regardless of second_tick or button inputs.
REQ-025 A button held high through reset release produces no edge until it is released and pressed again.

Configuration
REQ-026 Macro STOPWATCH_LAP_EN.
- Defined: a lap edge in RUNNING captures the live count into the snapshot and sets lap_active; a further lap edge clears lap_active.
- While lap_active, disp_* show the snapshot and the live count keeps advancing.
- A lap edge in IDLE or PAUSED is ignored; clear also clears lap_active.
REQ-027 Macro undefined: lap is ignored, lap_active is tied to 0, no snapshot registers exist, and disp_* always equal the live count.

Verification
REQ-028 Reset, start_stop pulse, 3 ticks -> state 01, timer_enable 1, disp 00:03.
REQ-029 RUNNING at 00:05, start_stop edge, 4 ticks, second start_stop edge, 1 tick -> state 01, disp 00:06; ticks issued while PAUSED are not counted.
REQ-030 MAX_MINUTES=1, count 01:59, 1 tick -> disp 00:00, rollover high exactly 1 cycle.
REQ-031 RUNNING at 00:10, clear and start_stop edges in the same cycle as a tick -> state 00, disp 00:00, timer_enable 0.
REQ-032 STOPWATCH_LAP_EN defined, RUNNING at 00:07, lap edge, 5 ticks -> disp 00:07, lap_active 1; lap edge -> disp 00:12.
REQ-033 start_stop held high for 10 cycles from IDLE -> exactly one transition to RUNNING; nrst low mid-count -> all outputs at their reset values the next cycle.
